// File: rtl/bus_master_port.sv
// Master-side bus front end: accepts one parallel request, arbitrates, then serializes
// the frame LSB-first. Optional WAIT_ACK/RDATA abort when BUS_MASTER_TIMEOUT_EN is defined.
module bus_master_port #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m_addr,
  input  logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_wen,
  input  logic                  m_wvalid,
  output logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  m_err,
  output logic                  breq,
  input  logic                  bgrant,
  output logic                  bus_mout,
  output logic                  bus_mvalid,
  input  logic                  bus_sin,
  input  logic                  bus_svalid,
  input  logic                  bus_ack
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {
    IDLE, REQ, WEN, ADDR, WDATA, WAIT_ACK, RDATA, DONE
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rd_sh;
  logic                  wen_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  accept;
  logic                  addr_last;
  logic                  data_last;
  logic                  rd_bit;
  logic                  rd_last;
  logic                  timeout;

  assign accept    = (state == IDLE) && m_wvalid;
  assign addr_last = (bit_cnt == CNT_W'(ADDR_WIDTH - 1));
  assign data_last = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign rd_bit    = (state == RDATA) && bus_svalid;
  assign rd_last   = rd_bit && data_last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    m_ready    = 1'b0;
    breq       = 1'b0;
    bus_mout   = 1'b0;
    bus_mvalid = 1'b0;
    case (state)
      IDLE: begin
        m_ready = 1'b1;
        if (m_wvalid) state_nxt = REQ;
      end
      REQ: begin
        breq = 1'b1;
        if (bgrant) state_nxt = WEN;
      end
      // Serial phases only advance while granted; a lost grant freezes the bit
      WEN: begin
        breq       = 1'b1;
        bus_mvalid = bgrant;
        bus_mout   = bgrant & wen_q;
        if (bgrant) state_nxt = ADDR;
      end
      ADDR: begin
        breq       = 1'b1;
        bus_mvalid = bgrant;
        bus_mout   = bgrant & addr_sh[0];
        if (bgrant && addr_last) state_nxt = wen_q ? WDATA : RDATA;
      end
      WDATA: begin
        breq       = 1'b1;
        bus_mvalid = bgrant;
        bus_mout   = bgrant & wdata_sh[0];
        if (bgrant && data_last) state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        breq = 1'b1;
        if (bus_ack || timeout) state_nxt = DONE;
      end
      RDATA: begin
        breq = 1'b1;
        if (rd_last || timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) breq = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_sh  <= '0;
      wdata_sh <= '0;
      rd_sh    <= '0;
      wen_q    <= 1'b0;
      bit_cnt  <= '0;
      m_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_sh  <= m_addr;
            wdata_sh <= m_wdata;
            wen_q    <= m_wen;
            rd_sh    <= '0;
            bit_cnt  <= '0;
          end
        end
        ADDR: begin
          if (bgrant) begin
            addr_sh <= addr_sh >> 1;
            bit_cnt <= addr_last ? '0 : bit_cnt + CNT_W'(1);
          end
        end
        WDATA: begin
          if (bgrant) begin
            wdata_sh <= wdata_sh >> 1;
            bit_cnt  <= data_last ? '0 : bit_cnt + CNT_W'(1);
          end
        end
        // Right shift: the first bit received ends up in bit 0
        RDATA: begin
          if (rd_bit) begin
            rd_sh   <= {bus_sin, rd_sh[DATA_WIDTH-1:1]};
            bit_cnt <= rd_last ? '0 : bit_cnt + CNT_W'(1);
            if (rd_last) m_rdata <= {bus_sin, rd_sh[DATA_WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            waiting;
  logic            err_set;

  assign waiting = (state == WAIT_ACK) || (state == RDATA);
  assign timeout = waiting && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  // A completion arriving on the timeout cycle wins
  assign err_set = timeout && !((state == WAIT_ACK) && bus_ack) && !rd_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      m_err  <= 1'b0;
    end else begin
      to_cnt <= waiting ? to_cnt + TO_W'(1) : '0;
      if (accept)       m_err <= 1'b0;
      else if (err_set) m_err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  // TIMEOUT_CYCLES is only meaningful in the timeout build
  assign m_err   = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_bus_master_port.sv
// Randomized bench for bus_master_port: a frame-level model predicts bus bits, completion,
// read data and abort status from the transaction parameters it drives.
module tb_bus_master_port;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 64;
`ifdef BUS_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_wen;
  logic          m_wvalid;
  logic          m_ready;
  logic [DW-1:0] m_rdata;
  logic          m_err;
  logic          breq;
  logic          bgrant;
  logic          bus_mout;
  logic          bus_mvalid;
  logic          bus_sin;
  logic          bus_svalid;
  logic          bus_ack;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_rdata = '0;
  logic          exp_err = 1'b0;

  always #5 clk = ~clk;

  bus_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen),
    .m_wvalid(m_wvalid), .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
    .breq(breq), .bgrant(bgrant), .bus_mout(bus_mout), .bus_mvalid(bus_mvalid),
    .bus_sin(bus_sin), .bus_svalid(bus_svalid), .bus_ack(bus_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gmode: 0 grant always, 1 random grant, 2 withheld 5 cycles then dropped 3 cycles at addr bit 7
  task automatic run_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic wen,
                         input logic [DW-1:0] rdval, input int gmode, input int ack_delay,
                         input bit spam, input int rst_at, input int exp_lat);
    bit            exp_q[$];
    bit            rx_q[$];
    logic [AW-1:0] as;
    logic [DW-1:0] ds;
    logic [DW-1:0] rs;
    logic [31:0]   exp_v;
    logic [31:0]   rx_v;
    int            lat = 0;
    int            sent = 0;
    int            wait_cnt = 0;
    int            drop_left = 3;
    bit            done_seen = 1'b0;
    bit            in_done;
    bit            frame_done;
    bit            to_hit = 1'b0;
    bit            breq_ok = 1'b1;
    bit            mv_ok = 1'b1;
    bit            finished = 1'b0;

    check("ready_before", 32'(m_ready), 1);
    exp_q.push_back(wen);
    as = a;
    for (int i = 0; i < AW; i++) begin exp_q.push_back(as[0]); as = as >> 1; end
    if (wen) begin
      ds = d;
      for (int i = 0; i < DW; i++) begin exp_q.push_back(ds[0]); ds = ds >> 1; end
    end

    m_addr = a; m_wdata = d; m_wen = wen; m_wvalid = 1'b1;
    bgrant = 1'b0; bus_ack = 1'b0; bus_svalid = 1'b0;
    tick();

    for (int k = 0; k < 4000; k++) begin
      m_wvalid   = 1'b0;
      bus_ack    = 1'b0;
      bus_svalid = 1'b0;
      bus_sin    = 1'($urandom);
      if (m_ready) begin finished = 1'b1; break; end
      in_done    = done_seen;
      frame_done = (rx_q.size() == exp_q.size());
      if (in_done) check("done_breq", 32'(breq), 0);

      case (gmode)
        0:       bgrant = 1'b1;
        1:       bgrant = ($urandom_range(0, 3) != 0);
        default: begin
          if (lat < 5) bgrant = 1'b0;
          else if (rx_q.size() == 8 && drop_left > 0) begin bgrant = 1'b0; drop_left--; end
          else bgrant = 1'b1;
        end
      endcase

      if (spam && !in_done) begin
        m_wvalid = 1'($urandom_range(0, 1));
        m_addr = 16'h09AC; m_wdata = 8'h54; m_wen = 1'($urandom);
      end

      if (!frame_done && !in_done) begin
        bus_ack    = ($urandom_range(0, 3) == 0);
        bus_svalid = ($urandom_range(0, 3) == 0);
      end else if (frame_done && !in_done) begin
        if (wen) begin
          bus_ack    = (wait_cnt == ack_delay);
          bus_svalid = 1'($urandom_range(0, 1));
          if (bus_ack) done_seen = 1'b1;
          else if (TO_EN && wait_cnt == TO - 1) begin done_seen = 1'b1; to_hit = 1'b1; end
        end else begin
          bus_ack    = 1'($urandom_range(0, 1));
          bus_svalid = ($urandom_range(0, 2) != 0);
          rs = rdval >> sent;
          bus_sin = rs[0];
          if (bus_svalid) begin
            sent++;
            if (sent == DW) done_seen = 1'b1;
          end
          if (!done_seen && TO_EN && wait_cnt == TO - 1) begin done_seen = 1'b1; to_hit = 1'b1; end
        end
        wait_cnt++;
      end

      if (rst_at >= 0 && rx_q.size() == rst_at) begin
        rst = 1'b1;
        bgrant = 1'b1;
        #1;
        check("rst_breq_now", 32'(breq), 0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_breq", 32'(breq), 0);
        check("rst_mvalid", 32'(bus_mvalid), 0);
        check("rst_ready", 32'(m_ready), 1);
        check("rst_rdata", 32'(m_rdata), 0);
        exp_rdata = '0;
        exp_err   = 1'b0;
        return;
      end

      #1;
      if (!in_done && !breq) breq_ok = 1'b0;
      if (bus_mvalid) begin
        if (frame_done || in_done || !bgrant) mv_ok = 1'b0;
        else rx_q.push_back(bus_mout);
      end
      tick();
      lat++;
    end

    m_wvalid = 1'b0; bus_ack = 1'b0; bus_svalid = 1'b0;
    check("completed", 32'(finished), 1);
    exp_v = '0;
    rx_v  = '0;
    for (int i = 0; i < exp_q.size(); i++) exp_v = exp_v | (32'(exp_q[i]) << i);
    for (int i = 0; i < rx_q.size() && i < 32; i++) rx_v = rx_v | (32'(rx_q[i]) << i);
    check("frame_len", rx_q.size(), exp_q.size());
    check("frame_bits", rx_v, exp_v);
    check("breq_held", 32'(breq_ok), 1);
    check("mvalid_ok", 32'(mv_ok), 1);
    if (!wen && !to_hit) exp_rdata = rdval;
    exp_err = to_hit;
    check("rdata", 32'(m_rdata), 32'(exp_rdata));
    check("err", 32'(m_err), 32'(exp_err));
    if (exp_lat > 0) check("latency", lat, exp_lat);
  endtask

  initial begin
    rst = 1'b1;
    m_addr = '0; m_wdata = '0; m_wen = 1'b0; m_wvalid = 1'b0;
    bgrant = 1'b0; bus_sin = 1'b0; bus_svalid = 1'b0; bus_ack = 1'b0;
    tick(); tick();
    // rst and a request on the same edge: request is dropped
    m_addr = 16'h1111; m_wdata = 8'h22; m_wen = 1'b1; m_wvalid = 1'b1; bgrant = 1'b1;
    tick();
    rst = 1'b0; m_wvalid = 1'b0;
    #1;
    check("reset_ready", 32'(m_ready), 1);
    check("reset_breq", 32'(breq), 0);
    check("reset_rdata", 32'(m_rdata), 0);
    check("reset_err", 32'(m_err), 0);
    check("reset_mout", 32'(bus_mout), 0);
    check("reset_mvalid", 32'(bus_mvalid), 0);
    tick();
    check("dropped_req_idle", 32'(m_ready), 1);
    check("dropped_req_breq", 32'(breq), 0);

    run_txn(16'h2ABC, 8'h29, 1'b1, 8'h00, 0, 0, 1'b0, -1, 28);
    run_txn(16'h2ABC, 8'h29, 1'b1, 8'h00, 0, 0, 1'b0, 20, 0);
    run_txn(16'h2ABC, 8'h00, 1'b0, 8'h29, 0, 0, 1'b0, -1, 0);
    run_txn(16'h2ABC, 8'h29, 1'b1, 8'h00, 2, 0, 1'b0, -1, 36);
    run_txn(16'h1357, 8'hA5, 1'b1, 8'h00, 0, 2, 1'b1, -1, 30);
`ifdef BUS_MASTER_TIMEOUT_EN
    run_txn(16'h0F0F, 8'h3C, 1'b1, 8'h00, 0, 1000, 1'b0, -1, 91);
    run_txn(16'h0F0F, 8'h3C, 1'b1, 8'h00, 0, 0, 1'b0, -1, 28);
`endif
    for (int n = 0; n < 24; n++) begin
      run_txn(16'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1,
              int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Master-side front end that feeds the shared system bus.
- Accepts one parallel request per transaction from a local master: addr, wdata, wen, wvalid pulse.
- Requests the bus from the arbiter, then serializes a frame LSB-first onto the bit-serial bus. Writes complete on a slave ack; reads complete once the slave's serial data has been collected into m_rdata.
- One instance sits between each master (m1, m2) and the arbiter/bus interconnect in top.

Parameters:
- ADDR_WIDTH, 16, address bits per frame.
- DATA_WIDTH, 8, data bits per frame.
- TIMEOUT_CYCLES, 64, cycles allowed in WAIT_ACK/RDATA before abort (only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- m_addr  in  ADDR_WIDTH  request address, sampled on accept.
- m_wdata  in  DATA_WIDTH  write data, sampled on accept.
- m_wen  in  1  1=write, 0=read, sampled on accept.
- m_wvalid  in  1  request strobe; a 1-cycle pulse is sufficient.
- m_ready  out  1  high when idle and able to accept a request.
- m_rdata  out  DATA_WIDTH  read result, valid while m_ready=1 after a read.
- m_err  out  1  last transaction aborted (optional feature only; tied 0 otherwise).
- breq  out  1  bus request to arbiter.
- bgrant  in  1  bus grant from arbiter.
- bus_mout  out  1  serial master-to-slave bit.
- bus_mvalid  out  1  qualifies bus_mout.
- bus_sin  in  1  serial slave-to-master read bit.
- bus_svalid  in  1  qualifies bus_sin.
- bus_ack  in  1  slave write acknowledge, 1-cycle pulse.

Behaviour:
- Reset values: state=IDLE, m_ready=1, m_rdata=0, m_err=0, breq=0, bus_mout=0, bus_mvalid=0; all counters and shadow registers 0.
- rst is synchronous and active-high. Asserting it in any state returns to IDLE on the next edge and drops breq immediately; the in-flight transaction is discarded.
- Accept rule:
  - In IDLE with m_wvalid=1, latch addr/wdata/wen into shadow registers and go to REQ.
  - m_ready goes 0 the following cycle.
  - m_wvalid while not IDLE is ignored; there is no queueing.
- FSM states: IDLE, REQ, WEN, ADDR, WDATA, WAIT_ACK, RDATA, DONE.
- REQ:
  - breq=1.
  - Stay until bgrant=1, then go to WEN.
  - breq stays 1 from REQ through the last cycle before DONE.
- WEN: drive bus_mout=wen, bus_mvalid=1 for one cycle.
- ADDR:
  - Shift out ADDR_WIDTH bits LSB-first, one per cycle, with bus_mvalid=1.
  - bit_cnt counts 0..ADDR_WIDTH-1.
  - Then go to WDATA if wen=1, else RDATA.
- WDATA: shift out DATA_WIDTH bits LSB-first, then go to WAIT_ACK.
- WAIT_ACK: bus_mvalid=0; on bus_ack=1 go to DONE.
- RDATA:
  - On each cycle with bus_svalid=1, shift bus_sin into the MSB of the read shift register (right shift). After DATA_WIDTH valid bits, bit 0 holds the first bit received.
  - Cycles with bus_svalid=0 are stalls.
  - After the DATA_WIDTH-th valid bit, copy to m_rdata and go to DONE.
- DONE: breq=0, go to IDLE; m_ready=1 from the next cycle.
- Grant loss:
  - If bgrant drops during WEN/ADDR/WDATA, bus_mvalid=0 and bit_cnt holds. Shifting resumes on the same bit when bgrant returns.
  - breq stays 1 throughout.
  - In WAIT_ACK and RDATA, grant is ignored.
- Write latency with grant on the first REQ cycle and zero-wait ack:
  - 1 (REQ) + 1 (WEN) + ADDR_WIDTH + DATA_WIDTH + 1 (WAIT_ACK) + 1 (DONE) cycles from accept to m_ready=1.
  - This is 28 cycles at defaults.
- bus_ack outside WAIT_ACK and bus_svalid outside RDATA are ignored.
- m_rdata holds its value across write transactions; it updates only on read completion.
- Simultaneous rst and m_wvalid: rst wins and the request is dropped.

Optional Feature:
- Macro: BUS_MASTER_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT_ACK/RDATA and increments each cycle spent there.
  - On reaching TIMEOUT_CYCLES, go to DONE with m_err=1; m_rdata is unchanged.
  - m_err clears on the next accepted request.
  - A timeout and an ack/last bit arriving on the same cycle count as success.
- When undefined: no counter, m_err tied 0, and WAIT_ACK/RDATA wait indefinitely.

Test Plan:
- Write 16'h2ABC/8'h29 with bgrant tied 1 and bus_ack 1 cycle after the last bit:
  - bus_mout sequence is 1, then BC-2A LSB-first, then 29 LSB-first.
  - m_ready returns after 28 cycles; breq is low in DONE.
- Read 16'h2ABC with slave returning 8'h29 over 8 svalid cycles containing 2 stall cycles:
  - m_rdata=8'h29 when m_ready rises; bus_mvalid is never high during RDATA.
- Grant withheld 5 cycles, then dropped for 3 cycles at address bit 7:
  - breq stays high throughout, no bits are skipped or repeated, and the frame is bit-identical to the first test.
- m_wvalid pulses with 16'h09AC/8'h54 while busy:
  - Ignored; only the first transaction appears on the bus.
- rst asserted for 1 cycle mid-WDATA:
  - Next cycle state=IDLE, breq=0, bus_mvalid=0, m_ready=1, m_rdata unchanged-from-reset 0.
- With BUS_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=64, write with no ack:
  - m_ready and m_err=1 after 64 WAIT_ACK cycles.
  - A following successful write clears m_err.
